// File: rtl/alu_driver.sv
// Drives an external 4-bit ALU one command at a time.
// It registers the operands, captures the result one cycle later and holds it until the consumer accepts it.
module alu_driver #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_sel,
  input  logic             cmd_acc,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  output logic [3:0]       A,
  output logic [3:0]       B,
  output logic             sel,
  input  logic [3:0]       result,
  input  logic             zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic             rsp_zero,
  output logic [3:0]       acc,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t           state_q;
  logic             cmd_ready_q;
  logic [3:0]       a_q, b_q;
  logic             sel_q;
  logic             rsp_valid_q;
  logic [3:0]       rsp_result_q;
  logic             rsp_zero_q;
  logic [3:0]       acc_q;
  logic [CNT_W-1:0] op_count_q;

  logic [3:0]       a_d;
  logic [CNT_W-1:0] op_count_d;

  always_comb begin
    a_d        = cmd_acc ? acc_q : cmd_a;
    op_count_d = op_count_q + CNT_W'(1);
  end

  // One edge loads operands, the next captures the ALU output, so latency is fixed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b1;
      a_q          <= 4'd0;
      b_q          <= 4'd0;
      sel_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 4'd0;
      rsp_zero_q   <= 1'b0;
      acc_q        <= 4'd0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            a_q         <= a_d;
            b_q         <= cmd_b;
            sel_q       <= cmd_sel;
            cmd_ready_q <= 1'b0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_result_q <= result;
          rsp_zero_q   <= zero;
          acc_q        <= result;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          // Returning to IDLE rather than accepting here enforces the 3-cycle minimum.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_d;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign A          = a_q;
  assign B          = b_q;
  assign sel        = sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign acc        = acc_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver with a behavioural ALU attached.
// Expected responses are queued at issue and checked by a monitor on consumption.
module tb_alu_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_sel, cmd_acc;
  logic [3:0] cmd_a, cmd_b, A, B;
  logic       sel;
  logic [3:0] alu_result;
  logic       alu_zero;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_zero;
  logic [3:0] acc;
  logic [7:0] op_count;

  typedef struct packed {
    logic [3:0] res;
    logic       zero;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_cnt = 8'd0;

  always #5 clk = ~clk;

  assign alu_result = sel ? (A & B) : (A + B);
  assign alu_zero   = (alu_result == 4'd0);

  alu_driver #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_acc(cmd_acc), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .A(A), .B(B), .sel(sel),
    .result(alu_result), .zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .acc(acc), .op_count(op_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: the cycle before the consuming edge, compare against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got %0h expected none", rsp_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_zero", rsp_zero, e.zero);
        chk("acc", acc, e.res);
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 8 && !cmd_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic s, input logic u,
                       input logic [3:0] ea, input logic [3:0] er, input logic ez);
    exp_t e;
    wait_ready();
    cmd_a = a; cmd_b = b; cmd_sel = s; cmd_acc = u; cmd_valid = 1'b1;
    e.res = er; e.zero = ez;
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("issue_cmd_ready", cmd_ready, 0);
    chk("issue_rsp_valid", rsp_valid, 0);
    chk("A", A, ea);
    chk("B", B, b);
    chk("sel", sel, s);
    @(posedge clk); #1;
    chk("latency_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    chk("consumed_rsp_valid", rsp_valid, 0);
    chk("op_count", op_count, exp_cnt);
    chk("idle_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1; cmd_valid = 1'b0; cmd_sel = 1'b0; cmd_acc = 1'b0;
    cmd_a = 4'd0; cmd_b = 4'd0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_sel", sel, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_acc", acc, 0);
    chk("rst_op_count", op_count, 0);

    // Directed vectors: a, b, sel, use_acc, expected A, result, zero.
    do_op(4'h7, 4'h9, 1'b0, 1'b0, 4'h7, 4'h0, 1'b1);
    do_op(4'hC, 4'hA, 1'b1, 1'b0, 4'hC, 4'h8, 1'b0);
    do_op(4'h2, 4'h3, 1'b0, 1'b0, 4'h2, 4'h5, 1'b0);
    do_op(4'hF, 4'h3, 1'b0, 1'b1, 4'h5, 4'h8, 1'b0);
    do_op(4'h3, 4'hC, 1'b1, 1'b0, 4'h3, 4'h0, 1'b1);
    do_op(4'h0, 4'h7, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1);

    // rsp_ready with no response pending changes nothing.
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("stray_ready_op_count", op_count, exp_cnt);
    chk("stray_ready_cmd_ready", cmd_ready, 1);

    // Backpressure: response held while a new command is pending.
    wait_ready();
    cmd_a = 4'h6; cmd_b = 4'h5; cmd_sel = 1'b0; cmd_acc = 1'b0; cmd_valid = 1'b1;
    e.res = 4'hB; e.zero = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_a = 4'h1; cmd_b = 4'h1; cmd_sel = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_result", rsp_result, 4'hB);
      chk("bp_rsp_zero", rsp_zero, 0);
      chk("bp_acc", acc, 4'hB);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_op_count", op_count, exp_cnt);
      chk("bp_A", A, 4'h6);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    chk("bp_done_op_count", op_count, exp_cnt);
    chk("bp_done_rsp_valid", rsp_valid, 0);
    chk("bp_done_cmd_ready", cmd_ready, 1);
    chk("bp_done_A", A, 4'h6);
    chk("bp_done_sel", sel, 0);

    // Reset while a response is waiting discards it.
    wait_ready();
    cmd_a = 4'h4; cmd_b = 4'h4; cmd_sel = 1'b0; cmd_acc = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    chk("pre_rst_acc", acc, 4'h8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 8'd0;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_op_count", op_count, 0);
    chk("mid_rst_A", A, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("sb_empty", sb.size(), 0);

    // 256 consumed operations wrap the counter back to zero.
    for (int i = 0; i < 256; i++) begin
      logic [3:0] a, b, r;
      logic       s;
      a = 4'(i);
      b = 4'(i >> 4);
      s = i[0];
      r = s ? (a & b) : (a + b);
      do_op(a, b, s, 1'b0, a, r, r == 4'd0);
      if (i == 254) chk("count_255", op_count, 8'd255);
    end
    chk("count_wrap", op_count, 0);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
